// File: rtl/ch_coef_load_ctrl_pkg.sv
// ch_coef_load_ctrl_pkg: shared RX channel-coefficient types, defaults and width helper
package ch_coef_load_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} ch_ctrl_state_t;
    localparam int CH_DEPTH = 13;
    localparam int CH_SYMS_PER_FRAME = 8;
    function automatic int ch_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ch_coef_load_ctrl_if.sv
// ch_coef_load_ctrl_if: estimator, coefficient-bank and equalizer handshake bundle
interface ch_coef_load_ctrl_if import ch_coef_load_ctrl_pkg::*; #(
    parameter int DEPTH = CH_DEPTH,
    parameter int SYMS_PER_FRAME = CH_SYMS_PER_FRAME
);
    logic i_coef_valid;
    logic o_coef_ready;
    logic o_wr_en;
    logic [ch_w(DEPTH)-1:0] o_wr_idx;
    logic o_equ_start;
    logic i_equ_done;
    logic [ch_w(SYMS_PER_FRAME)-1:0] o_sym_idx;
    modport master (
        input  i_coef_valid, i_equ_done,
        output o_coef_ready, o_wr_en, o_wr_idx, o_equ_start, o_sym_idx
    );
    modport slave (
        output i_coef_valid, i_equ_done,
        input  o_coef_ready, o_wr_en, o_wr_idx, o_equ_start, o_sym_idx
    );
endinterface

// File: rtl/ch_ctrl_timeout_cnt.sv
// ch_ctrl_timeout_cnt: clearable wait counter flagging the last allowed wait cycle
module ch_ctrl_timeout_cnt import ch_coef_load_ctrl_pkg::*; #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = ch_w(TIMEOUT);
    logic [TW-1:0] cnt;
    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    assign expired = en && cnt == TW'(TIMEOUT - 1);
endmodule

// File: rtl/ch_coef_load_ctrl.sv
// ch_coef_load_ctrl: loads one coefficient set per frame, then sequences equalizer starts per symbol
module ch_coef_load_ctrl import ch_coef_load_ctrl_pkg::*; #(
    parameter int DEPTH = CH_DEPTH,
    parameter int SYMS_PER_FRAME = CH_SYMS_PER_FRAME,
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_abort,
    ch_coef_load_ctrl_if.master bus,
    output logic o_busy,
    output logic o_frame_done,
    output logic o_err
);
    localparam int IDX_W = ch_w(DEPTH);
    localparam int SYM_W = ch_w(SYMS_PER_FRAME);
    ch_ctrl_state_t state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [SYM_W-1:0] sym, sym_nxt;
    logic err_nxt, expired, last_idx, last_sym;
    assign bus.o_wr_en = bus.i_coef_valid & bus.o_coef_ready;
    assign bus.o_wr_idx = idx;
    assign bus.o_sym_idx = sym;
    assign last_idx = idx == IDX_W'(DEPTH - 1);
    assign last_sym = sym == SYM_W'(SYMS_PER_FRAME - 1);
    ch_ctrl_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .i_rst_n(i_rst_n),
        .clr(i_abort || state != WAIT),
        .en(state == WAIT),
        .expired(expired)
    );
    always_comb begin
        state_nxt = state;
        idx_nxt = idx;
        sym_nxt = sym;
        err_nxt = i_start && state != IDLE;
        case (state)
            IDLE: if (i_start) begin
                state_nxt = LOAD;
                idx_nxt = '0;
                sym_nxt = '0;
            end
            LOAD: if (bus.o_wr_en) begin
                idx_nxt = last_idx ? '0 : idx + 1'b1;
                state_nxt = last_idx ? ISSUE : LOAD;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: if (bus.i_equ_done) begin
                state_nxt = last_sym ? DONE : ISSUE;
                sym_nxt = last_sym ? sym : sym + 1'b1;
            end else if (expired) begin
                state_nxt = IDLE;
                err_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // abort silences every pulse of its own cycle
        if (i_abort) begin
            state_nxt = IDLE;
            idx_nxt = '0;
            sym_nxt = '0;
            err_nxt = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state <= IDLE;
            idx <= '0;
            sym <= '0;
            bus.o_coef_ready <= 1'b0;
            bus.o_equ_start <= 1'b0;
            o_busy <= 1'b0;
            o_frame_done <= 1'b0;
            o_err <= 1'b0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
            sym <= sym_nxt;
            bus.o_coef_ready <= state_nxt == LOAD;
            bus.o_equ_start <= state_nxt == ISSUE;
            o_busy <= state_nxt != IDLE;
            o_frame_done <= state_nxt == DONE;
            o_err <= err_nxt;
        end
endmodule

// File: tb/tb_ch_coef_load_ctrl.sv
// tb_ch_coef_load_ctrl: directed frames checked every cycle against a counter-based frame model
module tb_ch_coef_load_ctrl;
    localparam int DEPTH = 13;
    localparam int SYMS = 8;
    localparam int TO = 1024;
    logic clk = 0, i_rst_n = 1, i_start = 0, i_abort = 0;
    logic o_busy, o_frame_done, o_err;
    int n_vec = 0, n_bad = 0, cyc = 0;
    int rdelay = 0, rcd = 0, rstarts = 0, skip_n = 0;
    logic force_done = 0;
    bit m_act, m_wait, m_start, m_fd, m_err, p_start, p_fd, p_busy;
    int m_nwr, m_age, m_sym;
    int wr_q[$], st_q[$];
    int n_fd = 0, fd_cyc = 0, n_err = 0, err_cyc = 0, wr_cyc = 0, fall_cyc = 0;
    int bw, bs, bf, be;
    ch_coef_load_ctrl_if #(.DEPTH(DEPTH), .SYMS_PER_FRAME(SYMS)) bus ();
    ch_coef_load_ctrl #(.DEPTH(DEPTH), .SYMS_PER_FRAME(SYMS), .TIMEOUT(TO)) dut (
        .clk(clk),
        .i_rst_n(i_rst_n),
        .i_start(i_start),
        .i_abort(i_abort),
        .bus(bus),
        .o_busy(o_busy),
        .o_frame_done(o_frame_done),
        .o_err(o_err)
    );
    always #5 clk = ~clk;
    function automatic void chk(input string nm, input logic [31:0] a, input int e);
        n_vec++;
        if (a !== 32'(e)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
        end
    endfunction
    // model: frame progress kept as counters of words taken, symbols done, cycles waited
    function automatic void model_update();
        p_start = m_start;
        p_fd = m_fd;
        m_start = 0;
        m_fd = 0;
        m_err = 0;
        if (i_abort) begin
            m_act = 0; m_nwr = 0; m_wait = 0; m_sym = 0;
        end else if (!m_act) begin
            if (i_start) begin m_act = 1; m_nwr = 0; m_wait = 0; m_sym = 0; end
        end else begin
            m_err = i_start;
            if (p_fd) m_act = 0;
            else if (m_nwr < DEPTH) begin
                if (bus.i_coef_valid) begin m_nwr++; m_start = m_nwr == DEPTH; end
            end else if (m_wait) begin
                if (bus.i_equ_done) begin
                    m_wait = 0;
                    if (m_sym == SYMS - 1) m_fd = 1;
                    else begin m_sym++; m_start = 1; end
                end else if (m_age == TO - 1) begin
                    m_wait = 0; m_act = 0; m_err = 1;
                end else m_age++;
            end else if (p_start) begin m_wait = 1; m_age = 0; end
        end
    endfunction
    task automatic step();
        logic done_now;
        done_now = rcd == 1;
        if (rcd > 0) rcd--;
        if (bus.o_equ_start === 1'b1) begin
            rstarts++;
            if (rstarts != skip_n) rcd = rdelay;
        end
        bus.i_equ_done = force_done | done_now;
        #1;
        if (!i_rst_n) begin
            chk("rst_coef_ready", 32'(bus.o_coef_ready), 0);
            chk("rst_wr_en", 32'(bus.o_wr_en), 0);
            chk("rst_wr_idx", 32'(bus.o_wr_idx), 0);
            chk("rst_equ_start", 32'(bus.o_equ_start), 0);
            chk("rst_sym_idx", 32'(bus.o_sym_idx), 0);
            chk("rst_busy", 32'(o_busy), 0);
            chk("rst_frame_done", 32'(o_frame_done), 0);
            chk("rst_err", 32'(o_err), 0);
            m_act = 0; m_wait = 0; m_start = 0; m_fd = 0; m_err = 0;
            m_nwr = 0; m_age = 0; m_sym = 0;
        end else begin
            chk("coef_ready", 32'(bus.o_coef_ready), int'(m_act && m_nwr < DEPTH));
            chk("wr_en", 32'(bus.o_wr_en), int'(bus.i_coef_valid && m_act && m_nwr < DEPTH));
            if (m_act && m_nwr < DEPTH) chk("wr_idx", 32'(bus.o_wr_idx), m_nwr);
            chk("equ_start", 32'(bus.o_equ_start), int'(m_start));
            chk("sym_idx", 32'(bus.o_sym_idx), m_sym);
            chk("busy", 32'(o_busy), int'(m_act));
            chk("frame_done", 32'(o_frame_done), int'(m_fd));
            chk("err", 32'(o_err), int'(m_err));
            model_update();
        end
        if (bus.o_wr_en === 1'b1) begin wr_q.push_back(int'(bus.o_wr_idx)); wr_cyc = cyc; end
        if (bus.o_equ_start === 1'b1) st_q.push_back(cyc);
        if (o_frame_done === 1'b1) begin n_fd++; fd_cyc = cyc; end
        if (o_err === 1'b1) begin n_err++; err_cyc = cyc; end
        if (p_busy && o_busy === 1'b0) fall_cyc = cyc;
        p_busy = o_busy === 1'b1;
        cyc++;
        @(negedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) step();
    endtask
    task automatic mark();
        bw = wr_q.size(); bs = st_q.size(); bf = n_fd; be = n_err;
    endtask
    task automatic start_frame();
        i_start = 1;
        step();
        i_start = 0;
    endtask
    task automatic load(input logic [3:0] pat, input int st_at, input int dn_at, input int ab_at);
        int base = wr_q.size();
        for (int k = 0; k < 200 && wr_q.size() - base < DEPTH; k++) begin
            bus.i_coef_valid = pat[k % 4];
            i_start = k == st_at;
            force_done = k == dn_at;
            i_abort = wr_q.size() - base == ab_at;
            step();
            if (i_abort) break;
        end
        bus.i_coef_valid = 0; i_start = 0; force_done = 0; i_abort = 0;
    endtask
    task automatic chk_writes(input int b);
        chk("wr_count", wr_q.size() - b, DEPTH);
        for (int i = 0; i < DEPTH && b + i < wr_q.size(); i++) chk("wr_order", wr_q[b + i], i);
    endtask
    initial begin
        bus.i_coef_valid = 0;
        bus.i_equ_done = 0;
        i_rst_n = 0;
        @(negedge clk);
        #1;
        idle(3);
        i_rst_n = 1;
        idle(2);
        // nominal frame, done 5 cycles after each start
        rdelay = 5; skip_n = 0; rstarts = 0;
        mark();
        start_frame();
        load(4'hF, -1, -1, -1);
        idle(70);
        chk_writes(bw);
        chk("nom_starts", st_q.size() - bs, SYMS);
        if (st_q.size() > bs + 1) begin
            chk("nom_first_start", st_q[bs], wr_cyc + 1);
            chk("nom_start_gap", st_q[bs + 1] - st_q[bs], 6);
        end
        chk("nom_frame_done", n_fd - bf, 1);
        chk("nom_busy_fall", fall_cyc, fd_cyc + 1);
        chk("nom_no_err", n_err - be, 0);
        chk("nom_sym_hold", 32'(bus.o_sym_idx), SYMS - 1);
        // gapped coefficient stream 1,0,0,1
        mark();
        start_frame();
        load(4'b1001, -1, -1, -1);
        idle(70);
        chk_writes(bw);
        if (st_q.size() > bs) chk("gap_first_start", st_q[bs], wr_cyc + 1);
        chk("gap_frame_done", n_fd - bf, 1);
        // timeout after the 3rd start
        skip_n = 3; rstarts = 0;
        mark();
        start_frame();
        load(4'hF, -1, -1, -1);
        idle(TO + 40);
        chk("to_starts", st_q.size() - bs, 3);
        chk("to_err_count", n_err - be, 1);
        if (st_q.size() > bs + 2) chk("to_err_time", err_cyc, st_q[bs + 2] + 1 + TO);
        chk("to_no_frame_done", n_fd - bf, 0);
        chk("to_idle", 32'(o_busy), 0);
        chk("to_sym_hold", 32'(bus.o_sym_idx), 2);
        // start while busy plus stray done during LOAD
        rdelay = 2; skip_n = 0; rstarts = 0;
        mark();
        start_frame();
        load(4'hF, 3, 5, -1);
        idle(40);
        chk("busy_err_count", n_err - be, 1);
        chk_writes(bw);
        chk("busy_starts", st_q.size() - bs, SYMS);
        chk("busy_frame_done", n_fd - bf, 1);
        // abort on the 7th coefficient, then restart from index 0
        rdelay = 5;
        mark();
        start_frame();
        load(4'hF, -1, -1, 6);
        idle(3);
        chk("abort_writes", wr_q.size() - bw, 7);
        chk("abort_idle", 32'(o_busy), 0);
        chk("abort_sym", 32'(bus.o_sym_idx), 0);
        chk("abort_no_start", st_q.size() - bs, 0);
        chk("abort_no_err", n_err - be, 0);
        mark();
        start_frame();
        load(4'hF, -1, -1, -1);
        idle(70);
        chk_writes(bw);
        chk("restart_frame_done", n_fd - bf, 1);
        // reset asserted while waiting for the equalizer
        rdelay = 20;
        mark();
        start_frame();
        load(4'hF, -1, -1, -1);
        idle(5);
        i_rst_n = 0;
        idle(3);
        i_rst_n = 1;
        idle(25);
        chk("rst_wait_starts", st_q.size() - bs, 1);
        chk("rst_wait_idle", 32'(o_busy), 0);
        chk("rst_wait_no_fd", n_fd - bf, 0);
        // done arrives on the last allowed wait cycle of every symbol
        rdelay = TO;
        mark();
        start_frame();
        load(4'hF, -1, -1, -1);
        idle(SYMS * (TO + 1) + 20);
        chk("coin_no_err", n_err - be, 0);
        chk("coin_starts", st_q.size() - bs, SYMS);
        if (st_q.size() > bs + 1) chk("coin_gap", st_q[bs + 1] - st_q[bs], TO + 1);
        chk("coin_frame_done", n_fd - bf, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ch_coef_load_ctrl.md
Name: ch_coef_load_ctrl

Overview:
Sequencing controller for the RX channel-coefficient path. Per frame, it collects DEPTH serial channel-estimate words into the parallel coefficient register bank by driving write enable and index. It then issues one equalizer start per data symbol, for SYMS_PER_FRAME symbols, and waits for each equalizer done. It sits between the channel estimator output and the coefficient bank / equalizer.

Parameters:
DEPTH, 13, number of coefficients per frame (subcarriers)
SYMS_PER_FRAME, 8, data symbols equalized with one coefficient set
TIMEOUT, 1024, max cycles waiting for i_equ_done before abort
IDX_W, $clog2(DEPTH), coefficient index width (derived, not overridden)

Ports:
clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  frame start pulse
i_abort  in  1  synchronous abort, returns to IDLE
i_coef_valid  in  1  estimator word valid
o_coef_ready  out  1  controller accepting coefficient words
o_wr_en  out  1  write strobe to coefficient bank
o_wr_idx  out  IDX_W  bank write index
o_equ_start  out  1  one-cycle equalizer start pulse
i_equ_done  in  1  equalizer finished current symbol
o_sym_idx  out  $clog2(SYMS_PER_FRAME)  current symbol number
o_busy  out  1  state != IDLE
o_frame_done  out  1  one-cycle pulse, frame completed
o_err  out  1  one-cycle pulse: timeout, or i_start while busy

Behaviour:
- Clock/reset: single clock clk; reset i_rst_n asynchronous, active-low. All state and outputs are registered except o_wr_en/o_wr_idx (see LOAD).
- Reset values: state IDLE; idx=0; sym=0; timer=0; all outputs 0.
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE: o_coef_ready=0. On i_start: idx<=0, sym<=0, go LOAD.
- LOAD: o_coef_ready=1 (state-decoded, registered).
  - o_wr_en = i_coef_valid & o_coef_ready (combinational). o_wr_idx = idx.
  - On each accepted word, idx++.
  - Accepted word with idx==DEPTH-1: idx<=0, go ISSUE on the next cycle. Exactly DEPTH writes per frame, indices 0..DEPTH-1 in order; idx never wraps within LOAD.
  - Cycles with valid low: no write, idx held (gaps allowed).
- ISSUE: o_equ_start=1 for exactly this one cycle; timer<=0; go WAIT.
  - First start occurs 1 cycle after the last coefficient write.
- WAIT: timer++ each cycle.
  - On i_equ_done:
    - If sym==SYMS_PER_FRAME-1, go DONE.
    - Else sym++ and go ISSUE. This gives back-to-back starts 2 cycles apart minimum.
  - If timer reaches TIMEOUT-1 without done: o_err pulse, go IDLE.
  - If done and timeout occur in the same cycle, done wins.
- DONE: o_frame_done=1 for one cycle; go IDLE.
- o_sym_idx = sym at all times; it holds its last value in IDLE until the next i_start.
- i_equ_done outside WAIT: ignored.
- i_coef_valid outside LOAD: ignored; no write occurs.
- i_start while busy: ignored for sequencing; o_err pulses one cycle.
- Simultaneous i_start & i_abort in IDLE: abort wins; stay IDLE.
- i_abort in any state: next state IDLE, idx/sym/timer cleared, no pulses emitted that cycle. o_wr_en is still combinationally valid in that cycle if in LOAD; the bank tolerates a stray write.
- Reset mid-operation: immediate return to reset values; the bank contents are not the controller's concern.
- Counter widths: timer sized $clog2(TIMEOUT); idx compare against DEPTH-1 is unsigned.

Decomposition:
- Shared RX package: state enum type ch_ctrl_state_t (IDLE, LOAD, ISSUE, WAIT, DONE) and default constants CH_DEPTH=13, CH_SYMS_PER_FRAME=8.
- One natural sub-module: ch_ctrl_timeout_cnt (clear/enable/expire counter), instantiated for the WAIT timer.
- Everything else is a single FSM body.

Test Plan:
- Nominal frame: i_start, then 13 consecutive valid words, equalizer done 5 cycles after each start -> wr_idx 0..12 with 13 wr_en, 8 o_equ_start pulses, o_sym_idx 0..7, one o_frame_done, o_busy falls the cycle after DONE.
- Gapped input: valid pattern 1,0,0,1 repeated -> still exactly 13 writes at indices 0..12, no index skip or repeat; ISSUE 1 cycle after the 13th write.
- Timeout: after the 3rd start, hold i_equ_done=0 -> o_err pulse exactly TIMEOUT cycles after WAIT entry, state IDLE, no o_frame_done.
- Busy start and stray done: i_start during LOAD plus i_equ_done during LOAD -> one o_err pulse, write sequence unaffected, done ignored.
- Abort/reset: i_abort at the 7th coefficient, then a new i_start -> writes restart at idx 0. Deassert i_rst_n during WAIT -> all outputs 0 asynchronously.
- Done/timeout coincidence: i_equ_done on timer==TIMEOUT-1 -> no o_err, sequence continues to the next ISSUE.
